// File: rtl/non_maximum_suppression_pkg.sv
// Shared image geometry plus gradient pixel types for the Canny pipeline.
package non_maximum_suppression_pkg;

  localparam int unsigned WIDTH          = 8;
  localparam int unsigned HEIGHT         = 6;
  localparam int unsigned REDUCED_WIDTH  = 8;
  localparam int unsigned REDUCED_HEIGHT = 6;
  localparam int unsigned STARTING_X     = 0;
  localparam int unsigned STARTING_Y     = 0;
  localparam int unsigned IMAGE_SIZE     = WIDTH * HEIGHT;

  localparam int unsigned MAG_W = 8;
  localparam int unsigned DIR_W = 2;
  localparam int unsigned PIX_W = MAG_W + DIR_W;

  // Quantised gradient direction from the Sobel stage.
  typedef enum logic [DIR_W-1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } grad_dir_t;

  // One gradient word as it sits in the input FIFO.
  typedef struct packed {
    grad_dir_t        dir;
    logic [MAG_W-1:0] mag;
  } pixel_t;

endpackage

// File: rtl/non_maximum_suppression_kernel.sv
// Combinational 3x3 non-maximum suppression for a single centre pixel.
module nms_kernel
  import non_maximum_suppression_pkg::*;
(
  input  pixel_t           p1,
  input  pixel_t           p2,
  input  pixel_t           p3,
  input  pixel_t           p4,
  input  pixel_t           p5,
  input  pixel_t           p6,
  input  pixel_t           p7,
  input  pixel_t           p8,
  input  pixel_t           p9,
  input  logic             border,
  output logic [MAG_W-1:0] result_c
);

  logic [MAG_W-1:0] a_c;
  logic [MAG_W-1:0] b_c;

  // Neighbour directions carry no meaning here; only the centre direction does.
  logic unused_dir_c;
  assign unused_dir_c = ^{p1.dir, p2.dir, p3.dir, p4.dir, p6.dir, p7.dir, p8.dir, p9.dir};

  // Pick the neighbour pair along the gradient and keep the centre only if it is a local max.
  always_comb begin
    a_c      = '0;
    b_c      = '0;
    result_c = '0;
    case (p5.dir)
      DIR_0:   begin a_c = p4.mag; b_c = p6.mag; end
      DIR_45:  begin a_c = p3.mag; b_c = p7.mag; end
      DIR_90:  begin a_c = p2.mag; b_c = p8.mag; end
      DIR_135: begin a_c = p1.mag; b_c = p9.mag; end
      default: begin a_c = '0;     b_c = '0;     end
    endcase
    if (!border && (p5.mag >= a_c) && (p5.mag >= b_c)) begin
      result_c = p5.mag;
    end
  end

endmodule

// File: rtl/non_maximum_suppression.sv
// Streaming Canny non-maximum suppression over the reduced ROI, one byte out per pixel.
module non_maximum_suppression
  import non_maximum_suppression_pkg::*;
#(
  parameter int unsigned WIDTH          = non_maximum_suppression_pkg::WIDTH,
  parameter int unsigned HEIGHT         = non_maximum_suppression_pkg::HEIGHT,
  parameter int unsigned REDUCED_WIDTH  = non_maximum_suppression_pkg::REDUCED_WIDTH,
  parameter int unsigned REDUCED_HEIGHT = non_maximum_suppression_pkg::REDUCED_HEIGHT,
  parameter int unsigned STARTING_X     = non_maximum_suppression_pkg::STARTING_X,
  parameter int unsigned STARTING_Y     = non_maximum_suppression_pkg::STARTING_Y
) (
  input  logic             clock,
  input  logic             reset,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [PIX_W-1:0] in_dout,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [MAG_W-1:0] out_din,
  output logic             frame_done
);

  localparam int unsigned SHIFT_REG_LEN = 2 * REDUCED_WIDTH + 3;
  localparam int unsigned PIXEL_COUNT   = REDUCED_WIDTH * REDUCED_HEIGHT;
  localparam int unsigned CNT_W         = $clog2(PIXEL_COUNT + 1);
  localparam int unsigned COL_W         = (REDUCED_WIDTH > 1) ? $clog2(REDUCED_WIDTH) : 1;
  localparam int unsigned ROW_W         = (REDUCED_HEIGHT > 1) ? $clog2(REDUCED_HEIGHT) : 1;
  localparam int unsigned W             = REDUCED_WIDTH;

  typedef enum logic [1:0] {
    PROLOGUE = 2'd0,
    NMS      = 2'd1,
    OUTPUT   = 2'd2
  } state_t;

  state_t           state;
  pixel_t           win [SHIFT_REG_LEN];
  logic [CNT_W-1:0] in_count;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [MAG_W-1:0] result_r;

  logic             drained_c;
  logic             prologue_pop_c;
  logic             eval_c;
  logic             nms_pop_c;
  logic             pop_c;
  logic             shift_c;
  pixel_t           shift_in_c;
  logic             last_col_c;
  logic             last_pixel_c;
  logic             border_c;
  logic [31:0]      full_x_c;
  logic [31:0]      full_y_c;
  logic [MAG_W-1:0] kernel_result_c;

  // Pop / evaluate decisions from the registered state and FIFO flags.
  always_comb begin
    drained_c      = (in_count == CNT_W'(PIXEL_COUNT));
    prologue_pop_c = (state == PROLOGUE) && (in_count < CNT_W'(W + 2)) && !in_empty;
    eval_c         = (state == NMS) && (!in_empty || drained_c);
    nms_pop_c      = eval_c && !drained_c;
    pop_c          = prologue_pop_c || nms_pop_c;
    shift_c        = prologue_pop_c || eval_c;
    shift_in_c     = pop_c ? pixel_t'(in_dout) : pixel_t'('0);
    last_col_c     = (col == COL_W'(W - 1));
    last_pixel_c   = last_col_c && (row == ROW_W'(REDUCED_HEIGHT - 1));
  end

  // Border flag: ROI edge (kills row-wrap garbage) or full-image edge.
  always_comb begin
    full_x_c = 32'(col) + STARTING_X;
    full_y_c = 32'(row) + STARTING_Y;
    border_c = (row == '0) || (row == ROW_W'(REDUCED_HEIGHT - 1)) ||
               (col == '0) || last_col_c ||
               (full_x_c == 32'd0) || (full_x_c == 32'(WIDTH - 1)) ||
               (full_y_c == 32'd0) || (full_y_c == 32'(HEIGHT - 1));
  end

  nms_kernel u_kernel (
    .p1       (win[0]),
    .p2       (win[1]),
    .p3       (win[2]),
    .p4       (win[W]),
    .p5       (win[W + 1]),
    .p6       (win[W + 2]),
    .p7       (win[2 * W]),
    .p8       (win[2 * W + 1]),
    .p9       (win[2 * W + 2]),
    .border   (border_c),
    .result_c (kernel_result_c)
  );

  // FIFO handshakes are driven straight from the registered state and held low in reset.
  assign in_rd_en   = !reset && pop_c;
  assign out_wr_en  = !reset && (state == OUTPUT) && !out_full;
  assign out_din    = reset ? '0 : result_r;
  assign frame_done = out_wr_en && last_pixel_c;

  // Window shift register, counters and PROLOGUE/NMS/OUTPUT sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= PROLOGUE;
      in_count <= '0;
      col      <= '0;
      row      <= '0;
      result_r <= '0;
      for (int i = 0; i < int'(SHIFT_REG_LEN); i++) begin
        win[i] <= '0;
      end
    end else begin
      if (shift_c) begin
        for (int i = 0; i < int'(SHIFT_REG_LEN) - 1; i++) begin
          win[i] <= win[i + 1];
        end
        win[SHIFT_REG_LEN - 1] <= shift_in_c;
      end
      if (pop_c) begin
        in_count <= in_count + CNT_W'(1);
      end
      case (state)
        PROLOGUE: begin
          if (prologue_pop_c && (in_count == CNT_W'(W + 1))) begin
            state <= NMS;
          end
        end
        NMS: begin
          if (eval_c) begin
            result_r <= kernel_result_c;
            state    <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (!out_full) begin
            if (last_pixel_c) begin
              col      <= '0;
              row      <= '0;
              in_count <= '0;
              state    <= PROLOGUE;
            end else begin
              if (last_col_c) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
              state <= NMS;
            end
          end
        end
        default: state <= PROLOGUE;
      endcase
    end
  end

endmodule

// File: tb/tb_non_maximum_suppression.sv
// Randomised bench for non_maximum_suppression against a 2-D image reference model.
module tb_non_maximum_suppression;
  import non_maximum_suppression_pkg::*;

  localparam int W   = 8;
  localparam int RH  = 6;
  localparam int FW  = 8;
  localparam int FH  = 6;
  localparam int SX  = 0;
  localparam int SY  = 0;
  localparam int PIX = W * RH;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_rd_en;
  logic       in_empty;
  logic [9:0] in_dout;
  logic       out_wr_en;
  logic       out_full;
  logic [7:0] out_din;
  logic       frame_done;

  always #5 clock = ~clock;

  non_maximum_suppression #(
    .WIDTH(FW), .HEIGHT(FH), .REDUCED_WIDTH(W), .REDUCED_HEIGHT(RH),
    .STARTING_X(SX), .STARTING_Y(SY)
  ) dut (
    .clock(clock), .reset(reset), .in_rd_en(in_rd_en), .in_empty(in_empty),
    .in_dout(in_dout), .out_wr_en(out_wr_en), .out_full(out_full),
    .out_din(out_din), .frame_done(frame_done)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] img  [PIX];
  logic [7:0] expv [PIX];
  logic [7:0] refv [PIX];
  logic [9:0] inq  [$];
  logic [7:0] got  [$];

  int cyc, pops, bad_pops, done_cnt, done_idx, done_cyc, first_wr_cyc, early_wr;
  int stall_pops, stall_wrs, stall_din_chg;

  // Reference: suppression computed directly on the 2-D image.
  function automatic void build_expected();
    for (int r = 0; r < RH; r++) begin
      for (int c = 0; c < W; c++) begin
        int i, dr, dc;
        logic [7:0] m, a, b;
        i = r * W + c;
        m = img[i][7:0];
        case (img[i][9:8])
          2'd0:    begin dr = 0; dc = 1;  end
          2'd1:    begin dr = 1; dc = -1; end
          2'd2:    begin dr = 1; dc = 0;  end
          default: begin dr = 1; dc = 1;  end
        endcase
        if (r == 0 || r == RH - 1 || c == 0 || c == W - 1 ||
            c + SX == 0 || c + SX == FW - 1 || r + SY == 0 || r + SY == FH - 1) begin
          expv[i] = 8'd0;
        end else begin
          a = img[(r - dr) * W + (c - dc)][7:0];
          b = img[(r + dr) * W + (c + dc)][7:0];
          expv[i] = (m >= a && m >= b) ? m : 8'd0;
        end
      end
    end
  endfunction

  function automatic void fill(input int mode, input int d);
    for (int i = 0; i < PIX; i++) begin
      case (mode)
        0: img[i] = {2'(d), 8'd50};
        1: img[i] = {2'(d), ((i % W) == 3) ? 8'd100 : 8'd40};
        default: img[i] = {2'($urandom_range(3)), 8'($urandom_range(255))};
      endcase
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_empty = 1'b1; out_full = 1'b0; in_dout = '0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    inq.delete(); got.delete(); cyc = 0; pops = 0;
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later, then move on.
  task automatic cycle(input bit starve, input bit full);
    logic [9:0] tmp;
    in_empty = starve || (inq.size() == 0);
    in_dout  = (inq.size() != 0) ? inq[0] : 10'h000;
    out_full = full;
    #1;
    cyc++;
    if (in_rd_en) begin
      if (in_empty) bad_pops++;
      if (inq.size() != 0) tmp = inq.pop_front();
      pops++;
    end
    if (out_wr_en) begin
      if (pops < W + 2) early_wr++;
      if (got.size() == 0) first_wr_cyc = cyc;
      got.push_back(out_din);
      if (frame_done) begin done_cnt++; done_idx = got.size(); done_cyc = cyc; end
    end else if (frame_done) begin
      done_cnt++;
    end
    @(negedge clock);
  endtask

  task automatic run_frame(input int starve_pct, input int starve_until, input int stall_pct,
                           input int stall_at, input int stall_len, input int abort_at,
                           output bit timed_out);
    int budget;
    bit stall_done;
    int p0, g0;
    logic [7:0] d0;
    for (int i = 0; i < PIX; i++) inq.push_back(img[i]);
    got.delete();
    pops = 0; bad_pops = 0; done_cnt = 0; done_idx = -1; done_cyc = -1;
    first_wr_cyc = -1; early_wr = 0; stall_pops = 0; stall_wrs = 0; stall_din_chg = 0;
    budget = 4000; stall_done = 0; timed_out = 0;
    while (done_cnt == 0) begin
      if (budget <= 0) begin timed_out = 1; break; end
      if (abort_at >= 0 && got.size() >= abort_at) break;
      if (!stall_done && stall_at >= 0 && got.size() == stall_at) begin
        cycle(1'b0, 1'b0);
        p0 = pops; g0 = got.size(); d0 = out_din;
        repeat (stall_len) begin
          cycle(1'b0, 1'b1);
          if (out_din !== d0) stall_din_chg++;
        end
        stall_pops = pops - p0; stall_wrs = got.size() - g0;
        stall_done = 1; budget -= stall_len + 1;
      end else begin
        cycle((pops < starve_until) && ($urandom_range(99) < starve_pct),
              $urandom_range(99) < stall_pct);
        budget--;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_empty = 1'b0; in_dout = 10'h3ff; out_full = 1'b0;
    repeat (3) begin
      #1;
      vectors += 4;
      if (in_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b expected 0", in_rd_en); end
      if (out_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b expected 0", out_wr_en); end
      if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", frame_done); end
      if (out_din !== 8'd0) begin miscompares++; $display("FAIL reset_din: got %0d expected 0", out_din); end
      @(negedge clock);
    end
  endtask

  task automatic test_uniform();
    bit to;
    fill(0, 0); build_expected(); do_reset();
    run_frame(0, 0, 0, -1, 0, -1, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL uniform_timeout: got timeout expected frame_done"); end
    for (int i = 0; i < PIX; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      vectors++;
      if (g !== expv[i]) begin miscompares++; $display("FAIL uniform_px%0d: got %0d expected %0d", i, g, expv[i]); end
    end
    for (int i = 0; i < PIX; i++) refv[i] = expv[i];
    vectors += 5;
    if (got.size() != PIX) begin miscompares++; $display("FAIL uniform_writes: got %0d expected %0d", got.size(), PIX); end
    if (done_cnt != 1 || done_idx != PIX) begin miscompares++; $display("FAIL uniform_done: got cnt %0d at %0d expected 1 at %0d", done_cnt, done_idx, PIX); end
    if (first_wr_cyc != W + 4) begin miscompares++; $display("FAIL first_write_cycle: got %0d expected %0d", first_wr_cyc, W + 4); end
    if (done_cyc != W + 2 + 2 * PIX) begin miscompares++; $display("FAIL frame_cycles: got %0d expected %0d", done_cyc, W + 2 + 2 * PIX); end
    if (bad_pops != 0 || pops != PIX) begin miscompares++; $display("FAIL uniform_pops: got %0d (%0d bad) expected %0d", pops, bad_pops, PIX); end
  endtask

  task automatic test_ridge(input int d);
    bit to;
    fill(1, d); build_expected(); do_reset();
    run_frame(0, 0, 0, -1, 0, -1, to);
    vectors++;
    if (to || got.size() != PIX) begin miscompares++; $display("FAIL ridge%0d_writes: got %0d expected %0d", d, got.size(), PIX); end
    for (int i = 0; i < PIX; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      vectors++;
      if (g !== expv[i]) begin miscompares++; $display("FAIL ridge%0d_px%0d: got %0d expected %0d", d, i, g, expv[i]); end
    end
    for (int r = 1; r < RH - 1; r++) begin
      logic [7:0] g3, g2;
      g3 = (r * W + 3 < got.size()) ? got[r * W + 3] : 8'hxx;
      g2 = (r * W + 2 < got.size()) ? got[r * W + 2] : 8'hxx;
      vectors += 2;
      if (g3 !== 8'd100) begin miscompares++; $display("FAIL ridge%0d_peak_r%0d: got %0d expected 100", d, r, g3); end
      if (g2 !== ((d == 2) ? 8'd40 : 8'd0)) begin miscompares++; $display("FAIL ridge%0d_side_r%0d: got %0d expected %0d", d, r, g2, (d == 2) ? 40 : 0); end
    end
  endtask

  task automatic test_diagonal(input int d);
    bit to;
    logic [7:0] g, want;
    for (int i = 0; i < PIX; i++) img[i] = 10'h000;
    img[2 * W + 2] = {2'(d), 8'd90};
    img[1 * W + 1] = {2'd0, 8'd95};
    build_expected(); do_reset();
    run_frame(20, PIX, 20, -1, 0, -1, to);
    g = (2 * W + 2 < got.size()) ? got[2 * W + 2] : 8'hxx;
    want = (d == 3) ? 8'd0 : 8'd90;
    vectors += 2;
    if (to || got.size() != PIX) begin miscompares++; $display("FAIL diag%0d_writes: got %0d expected %0d", d, got.size(), PIX); end
    if (g !== want) begin miscompares++; $display("FAIL diag%0d_centre: got %0d expected %0d", d, g, want); end
  endtask

  task automatic test_random_back_to_back();
    bit to;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      fill(2, 0); build_expected();
      run_frame(30, PIX, 30, -1, 0, -1, to);
      vectors += 2;
      if (to || got.size() != PIX || done_cnt != 1) begin miscompares++; $display("FAIL b2b%0d_frame: got %0d writes %0d dones expected %0d 1", f, got.size(), done_cnt, PIX); end
      if (bad_pops != 0 || pops != PIX) begin miscompares++; $display("FAIL b2b%0d_pops: got %0d (%0d bad) expected %0d", f, pops, bad_pops, PIX); end
      for (int i = 0; i < PIX; i++) begin
        logic [7:0] g;
        g = (i < got.size()) ? got[i] : 8'hxx;
        vectors++;
        if (g !== expv[i]) begin miscompares++; $display("FAIL b2b%0d_px%0d: got %0d expected %0d", f, i, g, expv[i]); end
      end
    end
  endtask

  task automatic test_stall();
    bit to;
    logic [7:0] base [PIX];
    fill(2, 0); build_expected();
    do_reset();
    run_frame(0, 0, 0, -1, 0, -1, to);
    for (int i = 0; i < PIX; i++) base[i] = (i < got.size()) ? got[i] : 8'hxx;
    do_reset();
    run_frame(0, 0, 0, 20, 20, -1, to);
    vectors += 4;
    if (to || got.size() != PIX) begin miscompares++; $display("FAIL stall_writes: got %0d expected %0d", got.size(), PIX); end
    if (stall_pops != 0) begin miscompares++; $display("FAIL stall_pops: got %0d expected 0", stall_pops); end
    if (stall_wrs != 0) begin miscompares++; $display("FAIL stall_writes_during: got %0d expected 0", stall_wrs); end
    if (stall_din_chg != 0) begin miscompares++; $display("FAIL stall_din_stable: got %0d changes expected 0", stall_din_chg); end
    for (int i = 0; i < PIX; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      vectors++;
      if (g !== expv[i] || g !== base[i]) begin miscompares++; $display("FAIL stall_px%0d: got %0d expected %0d", i, g, expv[i]); end
    end
  endtask

  task automatic test_starve_reset();
    bit to;
    fill(2, 0); build_expected(); do_reset();
    run_frame(60, W + 2, 10, -1, 0, 30, to);
    vectors += 2;
    if (early_wr != 0) begin miscompares++; $display("FAIL starve_early_write: got %0d expected 0", early_wr); end
    if (to || got.size() != 30) begin miscompares++; $display("FAIL starve_partial: got %0d expected 30", got.size()); end
    for (int i = 0; i < 30; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      vectors++;
      if (g !== expv[i]) begin miscompares++; $display("FAIL starve_px%0d: got %0d expected %0d", i, g, expv[i]); end
    end
    fill(0, 0); build_expected(); do_reset();
    run_frame(0, 0, 0, -1, 0, -1, to);
    vectors += 2;
    if (to || got.size() != PIX) begin miscompares++; $display("FAIL restart_writes: got %0d expected %0d", got.size(), PIX); end
    if (done_cnt != 1 || done_idx != PIX) begin miscompares++; $display("FAIL restart_done: got cnt %0d at %0d expected 1 at %0d", done_cnt, done_idx, PIX); end
    for (int i = 0; i < PIX; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      vectors++;
      if (g !== refv[i]) begin miscompares++; $display("FAIL restart_px%0d: got %0d expected %0d", i, g, refv[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_ridge(0);
    test_ridge(2);
    test_diagonal(3);
    test_diagonal(1);
    test_random_back_to_back();
    test_stall();
    test_starve_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/non_maximum_suppression.md
# non_maximum_suppression

Canny non-maximum-suppression stage sitting directly upstream of the hysteresis stage. It streams gradient pixels (magnitude plus quantised direction) from the Sobel-stage FIFO over the reduced region of interest. It thins edges with a 3x3 sliding window and pushes one 8-bit suppressed magnitude per reduced pixel, in raster order, into the FIFO that hysteresis drains.

## Interface
Parameters (sizes come from the shared globals package):
- REDUCED_WIDTH, globals: ROI width in pixels
- REDUCED_HEIGHT, globals: ROI height in pixels
- STARTING_X / STARTING_Y, globals: ROI origin in full-image coordinates
- SHIFT_REG_LEN, 2*REDUCED_WIDTH+3: window shift-register depth
- PIXEL_COUNT, REDUCED_WIDTH*REDUCED_HEIGHT: pixels per frame

Ports:
- clock  in  1  single clock domain
- reset  in  1  synchronous, active-high
- in_rd_en  out  1  pop request to the input FIFO
- in_empty  in  1  input FIFO empty
- in_dout  in  10  [9:8] direction (0=0°, 1=45°, 2=90°, 3=135°), [7:0] magnitude
- out_wr_en  out  1  push to the output FIFO
- out_full  in  1  output FIFO full
- out_din  out  8  suppressed magnitude
- frame_done  out  1  one-cycle pulse on the last write of a frame

## Operation
- Window: SHIFT_REG_LEN entries of 10 bits, shifted right with each consumed word (new word enters the last index).
- Centre pixel is at index W+1, where W = REDUCED_WIDTH.
- Neighbours: p1..p3 at indices 0..2, p4/p6 at W/W+2, p7..p9 at 2W..2W+2.
- in_count counts consumed words per frame. Once in_count == PIXEL_COUNT, each evaluation shifts in zero (10'h000) without popping.
- FSM PROLOGUE:
  - Pop while in_count < W+2 and !in_empty.
  - Go to NMS in the same cycle the (W+2)th word is popped.
  - Never pop beyond W+2 words in this state.
- FSM NMS, evaluation cycle:
  - An evaluation fires when !in_empty or in_count == PIXEL_COUNT.
  - On evaluation, compute from the *registered* window and register the result into result_r.
  - In the same cycle, shift in the next word (popped, or zero) and go to OUTPUT.
  - With no evaluation, hold.
- Suppression rule, chosen by the centre direction (neighbour pair a,b):
  - dir 0: a,b = p4,p6.
  - dir 1: a,b = p3,p7.
  - dir 2: a,b = p2,p8.
  - dir 3: a,b = p1,p9.
  - result = mag if mag >= a and mag >= b, else 0. Comparisons are unsigned 8-bit.
- Border:
  - Result is forced to 0 when row ∈ {0, REDUCED_HEIGHT-1} or col ∈ {0, W-1}. This kills row-wrap garbage.
  - Result is also forced to 0 when the full-image x = col+STARTING_X or y = row+STARTING_Y is on the image border.
- FSM OUTPUT:
  - When !out_full: out_wr_en=1, out_din=result_r, then advance col/row and return to NMS.
  - When out_full: hold all state, out_wr_en=0, no pop.
  - After the write for row=REDUCED_HEIGHT-1, col=W-1: pulse frame_done, clear row, col and in_count, and return to PROLOGUE. The window is not cleared.
- Popping is only ever allowed in PROLOGUE or NMS, never in OUTPUT.

## Timing
- Reset (synchronous): state=PROLOGUE, counters=0, window=0, result_r=0. While reset is high, in_rd_en, out_wr_en and frame_done are all 0 and out_din=0.
- Outputs in_rd_en, out_wr_en and out_din are combinational from the registered state.
- Throughput: 2 cycles per pixel when unstalled.
- Latency with an always-non-empty input and never-full output:
  - The first write occurs in cycle W+4 after reset release (W+2 pops, then NMS, then OUTPUT).
  - A frame takes W+2+2*PIXEL_COUNT cycles.
- Reset mid-frame: the frame is abandoned. The next word is treated as pixel 0 of a new frame.
- An input FIFO that is empty in OUTPUT is irrelevant. An output FIFO that is full in NMS is irrelevant, because the result is held until OUTPUT.
- frame_done and the final out_wr_en assert in the same cycle.

## Structure
- The globals package holds WIDTH, HEIGHT, REDUCED_WIDTH, REDUCED_HEIGHT, STARTING_X, STARTING_Y and IMAGE_SIZE.
- Add to the same package:
  - a 2-bit typedef grad_dir_t (DIR_0, DIR_45, DIR_90, DIR_135);
  - the 10-bit packed pixel struct (dir, mag).
- The state enum (PROLOGUE, NMS, OUTPUT) stays local.
- One combinational sub-module, nms_kernel: nine 10-bit window taps plus border flag in, 8-bit result out. It is unit-testable on its own.

## Test plan
Parameters for directed tests: W=8, REDUCED_HEIGHT=6, STARTING_X=STARTING_Y=0.
- Uniform mag 50, dir 0 -> 48 writes: interior 24 = 50, all 24 border pixels = 0; frame_done pulses once with the 48th write.
- Vertical ridge, col 3 = 100 and others 40, dir 0 -> interior col 3 = 100, other interior pixels with a ridge neighbour (col 2, col 4) = 0.
- Same ridge with dir 2 -> all interior pixels pass unchanged (100 or 40).
- Diagonal: centre (2,2)=90 dir 3 with (1,1)=95 -> (2,2) outputs 0; the same case with dir 1 -> outputs 90.
- Output stall: hold out_full high for 20 cycles mid-frame -> no pops, no writes and out_din stable; resuming gives a byte-exact match to the unstalled run.
- Input starvation in the prologue plus reset asserted at pixel 30 -> no writes before W+2 words; after reset, a fresh frame produces exactly 48 writes with outputs identical to the first test.
